// File: rtl/srrc_pkg.sv
// Shared definitions for the SRRC receive-side symbol slicer.
package srrc_pkg;

  localparam int unsigned DefOsr     = 4;
  localparam int unsigned DefDw      = 18;
  localparam int unsigned DefAcqSyms = 64;

  // Symbol codes as produced by the transmit-side up-sampler.
  localparam logic [1:0] SymPos = 2'b01;
  localparam logic [1:0] SymNeg = 2'b11;

  typedef enum logic [1:0] {
    StAcq,
    StDecide,
    StTrack
  } state_e;

  // Width that holds acq_syms magnitudes of a saturated dw-bit sample.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned acq_syms);
    return dw - 1 + $clog2(acq_syms);
  endfunction

endpackage

// File: rtl/srrc_phase_argmax.sv
// Combinational OSR-way argmax over unsigned per-phase accumulators.
// Ties resolve to the lowest phase index; all-zero input yields index 0.
module srrc_phase_argmax
  import srrc_pkg::*;
#(
  parameter int unsigned OSR   = DefOsr,
  parameter int unsigned ACC_W = acc_width(DefDw, DefAcqSyms),
  localparam int unsigned IdxW = $clog2(OSR)
) (
  input  logic [OSR-1:0][ACC_W-1:0] acc_i,
  output logic [IdxW-1:0]           best_o
);

  // Heap-ordered compare tree: leaves sit in index order, so the left child
  // always covers lower phases and winning ties on the left keeps the lowest.
  always_comb begin
    logic [ACC_W-1:0] val [2*OSR-1];
    logic [IdxW-1:0]  idx [2*OSR-1];
    for (int i = 0; i < int'(OSR); i++) begin
      val[OSR-1+i] = acc_i[i];
      idx[OSR-1+i] = IdxW'(i);
    end
    for (int m = int'(OSR) - 2; m >= 0; m--) begin
      if (val[2*m+2] > val[2*m+1]) begin
        val[m] = val[2*m+2];
        idx[m] = idx[2*m+2];
      end else begin
        val[m] = val[2*m+1];
        idx[m] = idx[2*m+1];
      end
    end
    best_o = idx[0];
  end

endmodule

// File: rtl/srrc_symbol_slicer.sv
// Receive-side symbol recovery after the SRRC filter: picks the sampling
// phase with the largest accumulated magnitude over a training window, then
// decimates to one sample per symbol and hard-slices it to a 2-bit code.
module srrc_symbol_slicer
  import srrc_pkg::*;
#(
  parameter int unsigned OSR      = DefOsr,
  parameter int unsigned ACQ_SYMS = DefAcqSyms,
  parameter int unsigned DW       = DefDw,
  parameter int unsigned ACC_W    = acc_width(DW, ACQ_SYMS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] Din,
  output logic [1:0]           Dout,
  output logic                 Dout_valid,
  output logic                 Locked
);

  localparam int unsigned PhW  = $clog2(OSR);
  localparam int unsigned N    = ACQ_SYMS * OSR;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);
  localparam logic [DW-1:0]   DinMin  = {1'b1, {(DW-1){1'b0}}};

  state_e                   state_q, state_d;
  logic [PhW-1:0]           ph_q, ph_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [OSR-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [PhW-1:0]           best_q, best_d;
  logic                     locked_q, locked_d;
  logic [1:0]               dout_q, dout_d;
  logic                     dout_valid_q, dout_valid_d;

  logic [DW-2:0]            mag;
  logic [PhW-1:0]           argmax_best;

  srrc_phase_argmax #(
    .OSR   (OSR),
    .ACC_W (ACC_W)
  ) u_argmax (
    .acc_i  (acc_q),
    .best_o (argmax_best)
  );

  // Saturating magnitude: the most negative code would overflow on negation.
  always_comb begin
    if (!Din[DW-1]) begin
      mag = Din[DW-2:0];
    end else if (Din == DinMin) begin
      mag = '1;
    end else begin
      mag = ~Din[DW-2:0] + (DW-1)'(1);
    end
  end

  // Free-running phase; OSR is a power of two so the wrap is implicit.
  always_comb begin
    ph_d = ph_q + PhW'(1);
  end

  // Acquisition / decision / tracking next-state and slicer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    best_d       = best_q;
    locked_d     = locked_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;

    case (state_q)
      StAcq: begin
        acc_d[ph_q] = acc_q[ph_q] + ACC_W'(mag);
        cnt_d       = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDecide;
        end
      end
      // The sample arriving in this cycle is dropped while the winner settles.
      StDecide: begin
        best_d   = argmax_best;
        locked_d = 1'b1;
        state_d  = StTrack;
      end
      StTrack: begin
        if (ph_q == best_q) begin
          dout_d       = Din[DW-1] ? SymNeg : SymPos;
          dout_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = StAcq;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StAcq;
      ph_q         <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      best_q       <= '0;
      locked_q     <= 1'b0;
      dout_q       <= 2'b00;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ph_q         <= ph_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      best_q       <= best_d;
      locked_q     <= locked_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign Dout       = dout_q;
  assign Dout_valid = dout_valid_q;
  assign Locked     = locked_q;

endmodule

// File: tb/tb_srrc_symbol_slicer.sv
// Self-checking bench for srrc_symbol_slicer (OSR=4, ACQ_SYMS=64, N=256).
module tb_srrc_symbol_slicer;

  localparam int OSR = 4;
  localparam int N   = 256;

  typedef struct {
    logic [1:0] sym;
    int         cyc;
  } exp_t;

  logic               clk;
  logic               reset;
  logic signed [17:0] Din;
  logic [1:0]         Dout;
  logic               Dout_valid;
  logic               Locked;

  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];
  bit   sym_bits [128];

  srrc_symbol_slicer dut (
    .clk        (clk),
    .reset      (reset),
    .Din        (Din),
    .Dout       (Dout),
    .Dout_valid (Dout_valid),
    .Locked     (Locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus patterns indexed by sample number k since reset release.
  function automatic logic signed [17:0] din_for(input int mode, input int k);
    int ph;
    int s;
    int v;
    int amp;
    ph = k % OSR;
    s  = k / OSR;
    v  = 0;
    case (mode)
      1: v = (ph == 2) ? 1000 : 0;
      2: v = (ph == 1) ? -131072 : 5;
      3: begin
        if (ph == 0)      v = (s % 2 == 1) ? -500 : 500;
        else if (ph == 3) v = (s % 3 == 1) ? -500 : 500;
        else              v = 0;
      end
      4: begin
        amp = (ph == 0) ? 200 : (ph == 1) ? 1000 : (ph == 2) ? 600 : 100;
        v = sym_bits[s] ? -amp : amp;
      end
      5: begin
        if (ph == 3) v = (s % 3 == 0) ? -700 : 700;
        else         v = (k % 2 == 1) ? -50 : 50;
      end
      default: v = 0;
    endcase
    return 18'(v);
  endfunction

  function automatic int abs_sat(input int v);
    if (v == -131072) return 131071;
    return (v < 0) ? -v : v;
  endfunction

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      reset = 1'b1;
      Din   = 18'sd12345;
    end
  endtask

  // Runs `cycles` samples starting at k=0 right after reset, modelling phase
  // selection and checking Locked, Dout_valid timing and Dout every cycle.
  task automatic run_stream(input int mode, input int cycles, input string tag);
    longint             acc [OSR];
    int                 best;
    logic [1:0]         hold;
    logic               exp_lock;
    logic signed [17:0] din;
    exp_t               e;
    for (int i = 0; i < OSR; i++) acc[i] = 0;
    best = 0;
    hold = 2'b00;
    sb_q.delete();
    for (int k = 0; k < cycles; k++) begin
      din = din_for(mode, k);
      @(posedge clk);
      #1;
      reset = 1'b0;
      Din   = din;
      if (k < N) acc[k % OSR] += abs_sat(int'(din));
      if (k == N) begin
        best = 0;
        for (int i = 1; i < OSR; i++) if (acc[i] > acc[best]) best = i;
      end
      if (k >= N + 1 && (k % OSR) == best && k + 1 < cycles) begin
        e.sym = (din < 0) ? 2'b11 : 2'b01;
        e.cyc = k + 1;
        sb_q.push_back(e);
      end
      @(negedge clk);
      exp_lock = (k >= N + 1);
      n_checks++;
      if (Locked !== exp_lock) begin
        n_fail++;
        $display("FAIL %s locked k=%0d got %b want %b", tag, k, Locked, exp_lock);
      end
      n_checks++;
      if (Dout_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s unexpected_valid k=%0d got Dout=%b want no pulse", tag, k, Dout);
        end else begin
          e = sb_q.pop_front();
          if (e.sym !== Dout || e.cyc != k) begin
            n_fail++;
            $display("FAIL %s symbol k=%0d got %b want %b at cycle %0d",
                     tag, k, Dout, e.sym, e.cyc);
          end
          hold = e.sym;
        end
      end else begin
        if (Dout_valid !== 1'b0 || Dout !== hold ||
            (sb_q.size() > 0 && sb_q[0].cyc == k)) begin
          n_fail++;
          $display("FAIL %s idle k=%0d got valid=%b Dout=%b want valid=0 Dout=%b",
                   tag, k, Dout_valid, Dout, hold);
        end
      end
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_symbols got %0d pending want 0", tag, sb_q.size());
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      reset = (i < 3);
      Din   = 18'sd12345;
      @(negedge clk);
      n_checks++;
      if (Dout !== 2'b00 || Dout_valid !== 1'b0 || Locked !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got Dout=%b valid=%b locked=%b want 00 0 0",
                 i, Dout, Dout_valid, Locked);
      end
    end
  endtask

  task automatic test_phase_pick();
    do_reset(2);
    run_stream(1, 300, "phase_pick");
  endtask

  task automatic test_neg_sat();
    do_reset(2);
    run_stream(2, 257, "neg_sat_acq");
    n_checks++;
    if (dut.acc_q[1] !== 23'd8388544) begin
      n_fail++;
      $display("FAIL neg_sat acc1 got %0d want 8388544", dut.acc_q[1]);
    end
    n_checks++;
    if (dut.acc_q[0] !== 23'd320) begin
      n_fail++;
      $display("FAIL neg_sat acc0 got %0d want 320", dut.acc_q[0]);
    end
    do_reset(1);
    run_stream(2, 300, "neg_sat_track");
  endtask

  task automatic test_tie_break();
    do_reset(2);
    run_stream(3, 320, "tie_break");
  endtask

  task automatic test_mid_acq_reset();
    do_reset(2);
    run_stream(5, 100, "mid_acq_pre");
    do_reset(1);
    run_stream(1, 300, "mid_acq_post");
  endtask

  task automatic test_back_to_back();
    do_reset(2);
    run_stream(4, 500, "stream_ph1");
    do_reset(1);
    run_stream(5, 400, "relock_ph3");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    Din      = 18'sd12345;
    for (int i = 0; i < 128; i++) sym_bits[i] = 1'($urandom_range(0, 1));
    test_reset();
    test_phase_pick();
    test_neg_sat();
    test_tie_break();
    test_mid_acq_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/srrc_symbol_slicer.md
# srrc_symbol_slicer

Receive-side counterpart of the SRRC pulse-shaping filter. Takes the filter's 18-bit signed sample stream, which runs one sample per clock at OSR samples per symbol. It acquires the best sampling phase by accumulating per-phase magnitude over a training window, then decimates to one sample per symbol. Each kept sample is hard-sliced back to the 2-bit symbol code the up-sampler fed to the filter. It sits directly after the SRRC output in the loopback/receive path.

## Interface
- OSR, 4, samples per symbol (up-sampling factor); power of two, 2..16
- ACQ_SYMS, 64, acquisition window length in symbols; power of two
- DW, 18, input sample width (two's complement)
- ACC_W, DW-1+clog2(ACQ_SYMS) = 23, per-phase magnitude accumulator width
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- Din  input  DW  signed filtered sample, one valid sample every clock
- Dout  output  2  sliced symbol: 2'b01 = +1, 2'b11 = -1
- Dout_valid  output  1  one-cycle pulse, Dout carries a new symbol
- Locked  output  1  high once sampling phase is chosen, until next reset

## Operation
- Free-running phase counter ph, 0..OSR-1, increments every cycle, wraps OSR-1 -> 0; sample index k counts cycles since reset release; ph = k mod OSR.
- States: ACQ -> DECIDE -> TRACK; TRACK is terminal until reset.
- ACQ (samples k = 0..N-1, N = ACQ_SYMS*OSR): acc[ph] += |Din|. |Din| is saturating: -2^(DW-1) maps to 2^(DW-1)-1. Accumulators never overflow at max input (64*131071 = 8388544 < 2^23).
- DECIDE (sample k = N, discarded): best = argmax(acc[0..OSR-1]). On ties the lowest index wins. If all accumulators are zero, best = 0. best is registered, Locked set.
- TRACK (k >= N+1): when ph == best, slice Din: Din[DW-1]=1 -> 2'b11, else 2'b01 (zero slices to +1). Dout/Dout_valid are registered from that sample.
- Dout holds its last value between pulses; Dout_valid is low on all non-selected phases.
- Reset at any time, including mid-ACQ or mid-TRACK, abandons all state. Accumulators clear, and a full N-sample window restarts from the first cycle after reset deasserts.

## Timing
- Reset values: Dout = 2'b00, Dout_valid = 0, Locked = 0, ph = 0, acc[*] = 0, state = ACQ.
- The first cycle with reset low is sample k = 0, ph = 0.
- Locked goes high in the cycle of sample k = N+1, registered at the end of DECIDE.
- Slice latency: exactly 1 clock. A sample presented in cycle k with ph == best produces Dout/Dout_valid in cycle k+1.
- Decimated throughput: one Dout_valid every OSR cycles in TRACK, no gaps, no jitter.
- The first symbol is the first k >= N+1 with k mod OSR == best.
- No backpressure; the downstream consumer must accept every Dout_valid pulse.

## Structure
- Shared package srrc_pkg:
  - OSR and DW defaults
  - symbol codes SYM_POS = 2'b01, SYM_NEG = 2'b11
  - state enum {ACQ, DECIDE, TRACK}
  - ACC_W derivation function
- One sub-module, srrc_phase_argmax: combinational OSR-way unsigned compare tree with lowest-index tie-break, outputting the best phase index. The top level holds the counters, accumulators, FSM and slicer.

## Test plan
Defaults OSR=4, ACQ_SYMS=64, N=256.
- Reset: hold reset 3 cycles with Din=12345 -> Dout=00, Dout_valid=0, Locked=0 throughout and one cycle after release.
- Phase pick: Din=+1000 at ph 2, 0 elsewhere, for 300 cycles -> Locked=1 from cycle 257; first Dout_valid in cycle 259 with Dout=01, then every 4 cycles.
- Negative and saturation: Din=-131072 at ph 1, +5 elsewhere -> best=1, acc[1]=8388544; TRACK samples of -131072 give Dout=11.
- Tie-break: |Din|=500 at ph 0 and ph 3 (signs mixed), 0 at ph 1, 2 -> best=0; Dout follows the sign at ph 0.
- Mid-acquisition reset: assert reset at k=100 for 1 cycle with the phase-2 pattern -> Locked stays low until 257 cycles after release; accumulator state from before reset has no effect.
- Golden loopback: drive the SRRC output from the I-channel up-sampled golden pattern -> after lock, the Dout sequence matches the non-zero golden symbols, offset by the filter group delay in symbols.
